// File: rtl/wb_bus_scheduler.sv
// wb_bus_scheduler: two-master Wishbone scheduler (interpreter vs core) with per-transaction ownership until ack.
// Define WB_SCHED_TIMEOUT_EN to force completion after TIMEOUT_CYCLES busy cycles without ack.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
module wb_bus_scheduler #(
  parameter bit FAIR = 1'b1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [`ADDR_SIZE-1:0] wb_addr_interpreter,
  input  logic                  wb_cs_interpreter,
  input  logic                  wb_we_interpreter,
  input  logic [`WORD_SIZE-1:0] wb_wdata_interpreter,
  output logic [`WORD_SIZE-1:0] wb_rdata_interpreter,
  output logic                  wb_ack_interpreter,
  input  logic [`ADDR_SIZE-1:0] wb_addr_core,
  input  logic                  wb_cs_core,
  input  logic                  wb_we_core,
  input  logic [`WORD_SIZE-1:0] wb_wdata_core,
  output logic [`WORD_SIZE-1:0] wb_rdata_core,
  output logic                  wb_ack_core,
  output logic [`ADDR_SIZE-1:0] wb_addr,
  output logic                  wb_cs,
  output logic                  wb_we,
  output logic [`WORD_SIZE-1:0] wb_wdata,
  input  logic [`WORD_SIZE-1:0] wb_rdata,
  input  logic                  wb_ack,
  output logic                  grant_core,
  output logic                  grant_interpreter,
  output logic                  timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_C} state_t;
  state_t state;
  logic last_core, busy_i, busy_c, tmo, done;
  assign busy_i = state == BUSY_I;
  assign busy_c = state == BUSY_C;
  assign done = (busy_i || busy_c) && (wb_ack || tmo);
`ifdef WB_SCHED_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = (busy_i || busy_c) && !wb_ack && cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state == IDLE) ? '0 : cnt + 8'd1;
`else
  assign tmo = 1'b0;
`endif
  // On a tie the master not served last wins; with FAIR=0 the core always wins.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last_core <= 1'b0;
    end else begin
      if (state == IDLE)
        state <= (wb_cs_core && (!wb_cs_interpreter || !FAIR || !last_core)) ? BUSY_C :
                 wb_cs_interpreter ? BUSY_I : IDLE;
      else if (done || !wb_cs)
        state <= IDLE;
      if (done) last_core <= busy_c;
    end
  assign wb_cs    = busy_c ? wb_cs_core    : busy_i ? wb_cs_interpreter    : 1'b0;
  assign wb_we    = busy_c ? wb_we_core    : busy_i ? wb_we_interpreter    : 1'b0;
  assign wb_addr  = busy_c ? wb_addr_core  : busy_i ? wb_addr_interpreter  : '0;
  assign wb_wdata = busy_c ? wb_wdata_core : busy_i ? wb_wdata_interpreter : '0;
  assign wb_ack_core          = busy_c && (wb_ack || tmo);
  assign wb_ack_interpreter   = busy_i && (wb_ack || tmo);
  assign wb_rdata_core        = (busy_c && !tmo) ? wb_rdata : '0;
  assign wb_rdata_interpreter = (busy_i && !tmo) ? wb_rdata : '0;
  assign grant_core        = busy_c;
  assign grant_interpreter = busy_i;
  assign timeout_err       = tmo;
endmodule

// File: tb/tb_wb_bus_scheduler.sv
// tb_wb_bus_scheduler: directed vector table for wb_bus_scheduler plus async-reset and fixed-priority sequences.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
module tb_wb_bus_scheduler;
  typedef struct {
    string n;
    bit rst, cs_c, cs_i, ack;
    logic [15:0] rd;
    int own;
    bit e_ack;
    logic [15:0] e_rd;
    bit e_te;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cs_c = 1'b0, cs_i = 1'b0, ack = 1'b0;
  logic we_c = 1'b1, we_i = 1'b0;
  logic [`ADDR_SIZE-1:0] addr_c = 16'h0010, addr_i = 16'h0020;
  logic [`WORD_SIZE-1:0] wd_c = 16'h1111, wd_i = 16'h2222, rd = '0;
  logic [`WORD_SIZE-1:0] rd_i, rd_c, wdata;
  logic [`ADDR_SIZE-1:0] addr;
  logic ack_i, ack_c, cs, we, gc, gi, te;
  logic [`WORD_SIZE-1:0] f_rd_i, f_rd_c, f_wdata;
  logic [`ADDR_SIZE-1:0] f_addr;
  logic f_ack_i, f_ack_c, f_cs, f_we, f_gc, f_gi, f_te;
  int n_vec = 0, n_err = 0;
  vec_t v[$];
  always #5 clk = ~clk;
  wb_bus_scheduler #(.FAIR(1'b1), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_addr_interpreter(addr_i), .wb_cs_interpreter(cs_i), .wb_we_interpreter(we_i),
    .wb_wdata_interpreter(wd_i), .wb_rdata_interpreter(rd_i), .wb_ack_interpreter(ack_i),
    .wb_addr_core(addr_c), .wb_cs_core(cs_c), .wb_we_core(we_c),
    .wb_wdata_core(wd_c), .wb_rdata_core(rd_c), .wb_ack_core(ack_c),
    .wb_addr(addr), .wb_cs(cs), .wb_we(we), .wb_wdata(wdata), .wb_rdata(rd), .wb_ack(ack),
    .grant_core(gc), .grant_interpreter(gi), .timeout_err(te));
  // Fixed-priority instance on a slave that acks in the first strobe cycle.
  wb_bus_scheduler #(.FAIR(1'b0), .TIMEOUT_CYCLES(4)) dut_f0 (
    .clk(clk), .rst_n(rst_n),
    .wb_addr_interpreter(addr_i), .wb_cs_interpreter(cs_i), .wb_we_interpreter(we_i),
    .wb_wdata_interpreter(wd_i), .wb_rdata_interpreter(f_rd_i), .wb_ack_interpreter(f_ack_i),
    .wb_addr_core(addr_c), .wb_cs_core(cs_c), .wb_we_core(we_c),
    .wb_wdata_core(wd_c), .wb_rdata_core(f_rd_c), .wb_ack_core(f_ack_c),
    .wb_addr(f_addr), .wb_cs(f_cs), .wb_we(f_we), .wb_wdata(f_wdata), .wb_rdata(rd), .wb_ack(f_cs),
    .grant_core(f_gc), .grant_interpreter(f_gi), .timeout_err(f_te));
  function automatic logic [70:0] expv(vec_t x);
    logic c = x.own == 2;
    logic i = x.own == 1;
    return {c, i, c ? x.cs_c : i ? x.cs_i : 1'b0, c, c & x.e_ack, i & x.e_ack, x.e_te,
            c ? 16'h0010 : i ? 16'h0020 : 16'h0000, c ? 16'h1111 : i ? 16'h2222 : 16'h0000,
            c ? x.e_rd : 16'h0000, i ? x.e_rd : 16'h0000};
  endfunction
  function automatic logic [70:0] actv();
    return {gc, gi, cs, we, ack_c, ack_i, te, addr, wdata, rd_c, rd_i};
  endfunction
  task automatic cmp(string name, logic [70:0] got, logic [70:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic run(vec_t x);
    @(negedge clk);
    rst_n = !x.rst;
    cs_c = x.cs_c;
    cs_i = x.cs_i;
    ack = x.ack;
    rd = x.rd;
    #2;
    cmp(x.n, actv(), expv(x));
  endtask
  initial begin
    v.push_back('{"reset", 1, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0});
    v.push_back('{"core_c0", 0, 1, 0, 0, 16'h0, 0, 0, 16'h0, 0});
    v.push_back('{"core_c1", 0, 1, 0, 0, 16'h0, 2, 0, 16'h0, 0});
    v.push_back('{"core_c2", 0, 1, 0, 0, 16'h0, 2, 0, 16'h0, 0});
    v.push_back('{"core_c3_ack", 0, 1, 0, 1, 16'hA5A5, 2, 1, 16'hA5A5, 0});
    v.push_back('{"core_c4_idle_ack_ignored", 0, 0, 0, 1, 16'hA5A5, 0, 0, 16'h0, 0});
    v.push_back('{"core_c5_idle", 0, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0});
    v.push_back('{"abort_a0", 0, 0, 1, 0, 16'h0, 0, 0, 16'h0, 0});
    v.push_back('{"abort_a1_grant_i", 0, 1, 1, 0, 16'h0, 1, 0, 16'h0, 0});
    v.push_back('{"abort_a2_cs_drop", 0, 1, 0, 0, 16'h0, 1, 0, 16'h0, 0});
    v.push_back('{"abort_a3_idle", 0, 1, 0, 0, 16'h0, 0, 0, 16'h0, 0});
    v.push_back('{"abort_a4_grant_c", 0, 1, 0, 0, 16'h0, 2, 0, 16'h0, 0});
    v.push_back('{"abort_a5_ack_c", 0, 1, 0, 1, 16'h1234, 2, 1, 16'h1234, 0});
    v.push_back('{"abort_a6_idle", 0, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0});
    v.push_back('{"tie_reset", 1, 1, 1, 0, 16'h0, 0, 0, 16'h0, 0});
    v.push_back('{"tie_t0", 0, 1, 1, 0, 16'h0, 0, 0, 16'h0, 0});
    v.push_back('{"tie_t1_core", 0, 1, 1, 1, 16'hBEEF, 2, 1, 16'hBEEF, 0});
    v.push_back('{"tie_t2", 0, 1, 1, 0, 16'h0, 0, 0, 16'h0, 0});
    v.push_back('{"tie_t3_intp", 0, 1, 1, 1, 16'hCAFE, 1, 1, 16'hCAFE, 0});
    v.push_back('{"tie_t4", 0, 1, 1, 0, 16'h0, 0, 0, 16'h0, 0});
    v.push_back('{"tie_t5_core", 0, 1, 1, 1, 16'h0001, 2, 1, 16'h0001, 0});
    v.push_back('{"tie_t6", 0, 1, 1, 0, 16'h0, 0, 0, 16'h0, 0});
    v.push_back('{"tie_t7_intp", 0, 1, 1, 1, 16'h0002, 1, 1, 16'h0002, 0});
    v.push_back('{"tmo_reset", 1, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0});
    v.push_back('{"tmo_c0", 0, 1, 0, 0, 16'h5555, 0, 0, 16'h0, 0});
    v.push_back('{"tmo_c1", 0, 1, 0, 0, 16'h5555, 2, 0, 16'h5555, 0});
    v.push_back('{"tmo_c2", 0, 1, 0, 0, 16'h5555, 2, 0, 16'h5555, 0});
    v.push_back('{"tmo_c3", 0, 1, 0, 0, 16'h5555, 2, 0, 16'h5555, 0});
`ifdef WB_SCHED_TIMEOUT_EN
    v.push_back('{"tmo_c4_forced", 0, 1, 0, 0, 16'h5555, 2, 1, 16'h0, 1});
    v.push_back('{"tmo_c5_idle", 0, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0});
`else
    for (int k = 4; k < 12; k++) v.push_back('{"tmo_held", 0, 1, 0, 0, 16'h5555, 2, 0, 16'h5555, 0});
    v.push_back('{"tmo_abort", 0, 0, 0, 0, 16'h0, 2, 0, 16'h0, 0});
    v.push_back('{"tmo_idle", 0, 0, 0, 0, 16'h0, 0, 0, 16'h0, 0});
`endif
    foreach (v[k]) run(v[k]);
    // Complete one core transfer so last_core=1, then reset in the middle of the next one.
    run('{"mr_c0", 0, 1, 0, 0, 16'h0, 0, 0, 16'h0, 0});
    run('{"mr_c1", 0, 1, 0, 0, 16'h0, 2, 0, 16'h0, 0});
    run('{"mr_c2_ack", 0, 1, 0, 1, 16'h7777, 2, 1, 16'h7777, 0});
    run('{"mr_c3", 0, 1, 0, 0, 16'h0, 0, 0, 16'h0, 0});
    run('{"mr_c4_busy", 0, 1, 0, 1, 16'h3333, 2, 1, 16'h3333, 0});
    #1 rst_n = 1'b0;
    #1 cmp("mr_async_reset", actv(), 71'h0);
    run('{"mr_hold", 1, 1, 1, 0, 16'h0, 0, 0, 16'h0, 0});
    run('{"mr_release", 0, 1, 1, 0, 16'h0, 0, 0, 16'h0, 0});
    run('{"mr_core_first", 0, 1, 1, 0, 16'h0, 2, 0, 16'h0, 0});
    run('{"f0_reset", 1, 1, 1, 0, 16'h0, 0, 0, 16'h0, 0});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      cmp($sformatf("f0_cycle%0d", k), 71'({f_gc, f_gi, f_ack_c, f_ack_i}),
          71'({k % 2 == 1, 1'b0, k % 2 == 1, 1'b0}));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
